char_plane_reader: RTL and testbench
====================================

// Module: char_plane_reader
// PURPOSE
//  Read side of the 7x20 character plane. Walks the VGA pixel stream (x,y) and drives the
//  plane's read address (rout/cout). It takes the stored code from dout and fetches the
//  glyph row from the synchronous font ROM, then emits 12-bit RGB with a blinking underline
//  cursor. Sits between the VGA sync generator and the DAC pins; hsync/vsync are delayed to match.
// PARAMETERS
//  CELL_W       32         pixels per character column (8-px glyph, x4 scale); 20*32 = 640
//  CELL_H       64         lines per character row (16-line glyph, x4 scale); 7*64 = 448
//  BLANK_CODE   129        code rendered as background (0xFF also background)
//  FG_COLOR     12'hFFF    glyph/cursor colour
//  BG_COLOR     12'h000    background colour inside and outside text area
//  BLINK_CYCLES 25_000_000 clk cycles per cursor blink half-period
//  SYNC_IDLE    1'b1       reset value of hsync_out/vsync_out
// PORTS
//  clk         in   1   system clock; all state changes on rising edge
//  reset       in   1   asynchronous reset, active-high
//  x           in   10  pixel column from sync generator, 0..799
//  y           in   10  pixel line from sync generator, 0..524
//  video_on    in   1   1 = visible pixel (x<640, y<480)
//  hsync_in    in   1   horizontal sync from sync generator
//  vsync_in    in   1   vertical sync from sync generator
//  cout        out  6   plane read column, 0..19
//  rout        out  4   plane read row, 0..6
//  dout        in   8   character code from plane (combinational from rout/cout)
//  font_addr   out  12  font ROM address = {code[7:0], glyph_row[3:0]}
//  font_row    in   8   font ROM data, valid 1 clk after font_addr; bit7 = leftmost pixel
//  cursor_col  in   6   cursor column
//  cursor_row  in   4   cursor row
//  cursor_en   in   1   1 = draw cursor
//  rgb         out  12  pixel colour {R4,G4,B4}
//  hsync_out   out  1   hsync_in delayed 4 clk
//  vsync_out   out  1   vsync_in delayed 4 clk
// BEHAVIOUR
//  Reset (async): cout=0, rout=0, font_addr=0, rgb=0, hsync_out=vsync_out=SYNC_IDLE.
//   All pipeline valid/area flags are cleared; blink counter=0 and blink_phase=0.
//  Pipeline: x/y/video_on/syncs presented before edge N -> rgb/hsync_out/vsync_out after edge N+3 (latency 4 edges incl. N).
//   E1 (edge N):   in_area = video_on & y<7*CELL_H; cout=x/CELL_W, rout=y/CELL_H (0 if !in_area);
//                  bit_idx=(x%CELL_W)/4, glyph_row=(y%CELL_H)/4, cur_hit=cursor_en & cell==cursor.
//   E2 (edge N+1): font_addr={dout,glyph_row}; blank = (dout==BLANK_CODE | dout==8'hFF); carry flags.
//   E3 (edge N+2): ROM registers font_row (external); carry flags.
//   E4 (edge N+3): rgb computed as follows.
//     !video_on -> 0.
//     !in_area or blank -> BG_COLOR, except the cursor rule.
//     Otherwise FG_COLOR if font_row[7-bit_idx], else BG_COLOR.
//     Cursor rule: cur_hit & blink_phase & glyph_row>=14 -> FG_COLOR. This overrides blank and glyph but not !video_on.
//  Syncs pass through a 4-deep shift register, so they stay exactly aligned to rgb.
//  Blink: counter 0..BLINK_CYCLES-1. blink_phase toggles on wrap; it runs continuously, independent of video timing.
//  Address bounds: cout<=19 and rout<=6 always; never index the plane out of range (x>=640 or y>=448 -> 0,0).
//  cursor_col>19 or cursor_row>6: never hits, no cursor drawn.
//  dout/cursor inputs change mid-frame: take effect at the next pixel sampled; no glitch suppression required.
//  Reset mid-line: outputs go to reset values immediately. The first valid rgb appears 4 edges after the first edge with reset=0.
// TESTING
//  1 Reset asserted mid-stream -> rgb=0, sync outs=1 same cycle; release -> rgb valid exactly 4 edges later.
//  2 Plane all 129, x=0..639,y=0..479 -> every rgb=BG_COLOR; cout never >19, rout never >6.
//  3 Code 8'h41 at (r2,c5), font_row=8'b1000_0001 -> x=160..163,y=128 gives FG; x=164 BG; x=188..191 FG; rgb lags x by 4.
//  4 y=448..479 with nonzero codes in plane -> BG_COLOR, rout=cout=0; x>=640 (video_on=0) -> rgb=0.
//  5 Cursor (r0,c0), BLINK_CYCLES=4 -> lines y=56..63,x=0..31 show FG only while blink_phase=1, toggling every 4 clk; cursor_col=25 -> never FG.
//  6 hsync_in pulse 96 clk wide at x=656 -> hsync_out identical pulse shifted 4 clk, same edge as rgb of that x.

Source files
------------

// File: rtl/char_plane_reader.sv
// Read side of the 7x20 character plane: turns the VGA pixel stream into plane/font
// lookups and 12-bit RGB with a blinking underline cursor, syncs delayed to match.
module char_plane_reader #(
    parameter int          CELL_W       = 32,
    parameter int          CELL_H       = 64,
    parameter logic [7:0]  BLANK_CODE   = 8'd129,
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BLINK_CYCLES = 25_000_000,
    parameter logic        SYNC_IDLE    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [5:0]  cout,
    output logic [3:0]  rout,
    input  logic [7:0]  dout,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_row,
    input  logic [5:0]  cursor_col,
    input  logic [3:0]  cursor_row,
    input  logic        cursor_en,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [9:0] AREA_W = 10'(20 * CELL_W);
    localparam logic [9:0] AREA_H = 10'(7 * CELL_H);
    localparam int PIX_W  = CELL_W / 8;
    localparam int LINE_H = CELL_H / 16;
    localparam int CNT_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic        in_area_s;
    logic [5:0]  col_s;
    logic [3:0]  row_s;
    logic [5:0]  cout_s;
    logic [3:0]  rout_s;
    logic [2:0]  bit_idx_s;
    logic [3:0]  glyph_row_s;
    logic        cur_line_s;
    logic [11:0] rgb_s;

    logic [2:0]  bit_idx1_r, bit_idx2_r, bit_idx3_r;
    logic [3:0]  glyph_row1_r;
    logic        cur1_r, cur2_r, cur3_r;
    logic        area1_r, area2_r, area3_r;
    logic        von1_r, von2_r, von3_r;
    logic        blank2_r, blank3_r;
    logic [3:0]  hs_pipe_r, vs_pipe_r;
    logic [CNT_W-1:0] blink_cnt_r;
    logic        blink_phase_r;

    // Cell decode of the incoming pixel; anything outside the text area reads cell (0,0)
    always_comb begin
        in_area_s   = video_on && (x < AREA_W) && (y < AREA_H);
        col_s       = 6'(x / CELL_W);
        row_s       = 4'(y / CELL_H);
        bit_idx_s   = 3'((x % CELL_W) / PIX_W);
        glyph_row_s = 4'((y % CELL_H) / LINE_H);
        if (in_area_s) begin
            cout_s = col_s;
            rout_s = row_s;
        end else begin
            cout_s = 6'd0;
            rout_s = 4'd0;
        end
        // out-of-range cursor coordinates can never equal an in-area cell
        cur_line_s = cursor_en && in_area_s && (col_s == cursor_col) &&
                     (row_s == cursor_row) && (glyph_row_s >= 4'd14);
    end

    // Stage 1: plane address and per-pixel flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cout         <= 6'd0;
            rout         <= 4'd0;
            bit_idx1_r   <= 3'd0;
            glyph_row1_r <= 4'd0;
            cur1_r       <= 1'b0;
            area1_r      <= 1'b0;
            von1_r       <= 1'b0;
        end else begin
            cout         <= cout_s;
            rout         <= rout_s;
            bit_idx1_r   <= bit_idx_s;
            glyph_row1_r <= glyph_row_s;
            cur1_r       <= cur_line_s;
            area1_r      <= in_area_s;
            von1_r       <= video_on;
        end
    end

    // Stage 2: font address from the stored code, blank detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            font_addr  <= 12'd0;
            blank2_r   <= 1'b0;
            bit_idx2_r <= 3'd0;
            cur2_r     <= 1'b0;
            area2_r    <= 1'b0;
            von2_r     <= 1'b0;
        end else begin
            font_addr  <= {dout, glyph_row1_r};
            blank2_r   <= (dout == BLANK_CODE) || (dout == 8'hFF);
            bit_idx2_r <= bit_idx1_r;
            cur2_r     <= cur1_r;
            area2_r    <= area1_r;
            von2_r     <= von1_r;
        end
    end

    // Stage 3: flags wait alongside the external font ROM read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank3_r   <= 1'b0;
            bit_idx3_r <= 3'd0;
            cur3_r     <= 1'b0;
            area3_r    <= 1'b0;
            von3_r     <= 1'b0;
        end else begin
            blank3_r   <= blank2_r;
            bit_idx3_r <= bit_idx2_r;
            cur3_r     <= cur2_r;
            area3_r    <= area2_r;
            von3_r     <= von2_r;
        end
    end

    // Pixel colour; cursor beats blank and glyph but never lights the border
    always_comb begin
        rgb_s = BG_COLOR;
        if (!von3_r) begin
            rgb_s = 12'h000;
        end else if (cur3_r && blink_phase_r) begin
            rgb_s = FG_COLOR;
        end else if (!area3_r || blank3_r) begin
            rgb_s = BG_COLOR;
        end else if (font_row[3'd7 - bit_idx3_r]) begin
            rgb_s = FG_COLOR;
        end else begin
            rgb_s = BG_COLOR;
        end
    end

    // Stage 4: registered colour output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb <= 12'h000;
        end else begin
            rgb <= rgb_s;
        end
    end

    // Sync delay line matching the four-edge colour pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_pipe_r <= {4{SYNC_IDLE}};
            vs_pipe_r <= {4{SYNC_IDLE}};
        end else begin
            hs_pipe_r <= {hs_pipe_r[2:0], hsync_in};
            vs_pipe_r <= {vs_pipe_r[2:0], vsync_in};
        end
    end

    assign hsync_out = hs_pipe_r[3];
    assign vsync_out = vs_pipe_r[3];

    // Free-running blink timer, independent of video timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_r   <= {CNT_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (blink_cnt_r == CNT_LAST) begin
            blink_cnt_r   <= {CNT_W{1'b0}};
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + 1'b1;
            blink_phase_r <= blink_phase_r;
        end
    end

endmodule

// File: tb/tb_char_plane_reader.sv
// Self-checking bench for char_plane_reader: directed line sweeps plus randomized planes,
// fonts and cursors, compared against a pixel-level reference model.
module tb_char_plane_reader;

    localparam int          B  = 4;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h035;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        video_on, hsync_in, vsync_in;
    logic [5:0]  cout;
    logic [3:0]  rout;
    logic [7:0]  dout;
    logic [11:0] font_addr;
    logic [7:0]  font_row;
    logic [5:0]  cursor_col;
    logic [3:0]  cursor_row;
    logic        cursor_en;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out;

    logic [7:0] plane [0:6][0:19];
    logic [7:0] rom [0:4095];

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;

    char_plane_reader #(
        .BG_COLOR(BG), .FG_COLOR(FG), .BLINK_CYCLES(B)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .cout(cout), .rout(rout),
        .dout(dout), .font_addr(font_addr), .font_row(font_row),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    assign dout = (rout <= 4'd6 && cout <= 6'd19) ? plane[rout][cout] : 8'h00;

    always @(posedge clk) font_row <= rom[font_addr];

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference pixel colour from cell arithmetic on the plane and font tables
    function automatic logic [11:0] model_rgb(input int px, input int py, input logic von,
                                              input logic ph);
        int col, row, gr, bi;
        logic [7:0] code, bits;
        logic in_area, hit;
        if (!von) return 12'h000;
        in_area = (py < 448);
        col = px / 32; row = py / 64; gr = (py % 64) / 4; bi = (px % 32) / 4;
        hit = in_area && cursor_en && (col == int'(cursor_col)) &&
              (row == int'(cursor_row)) && (gr >= 14);
        if (hit && ph) return FG;
        if (!in_area) return BG;
        code = plane[row][col];
        if (code == 8'd129 || code == 8'hFF) return BG;
        bits = rom[{code, 4'(gr)}];
        return bits[7 - bi] ? FG : BG;
    endfunction

    task automatic prefill();
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back('{12'h000, 1'b1, 1'b1});
        edge_cnt = 0;
    endtask

    task automatic step(input int px, input int py);
        exp_t ex;
        logic von;
        logic [5:0] ec;
        logic [3:0] er;
        von = (px < 640) && (py < 480);
        x = px[9:0];
        y = py[9:0];
        video_on = von;
        hsync_in = !(px >= 656 && px < 752);
        vsync_in = !(py >= 490 && py < 492);
        ex.rgb = model_rgb(px, py, von, ((edge_cnt + 3) / B) % 2 == 1);
        ex.hs = hsync_in;
        ex.vs = vsync_in;
        q.push_back(ex);
        @(posedge clk);
        #1;
        edge_cnt++;
        ec = (von && py < 448) ? 6'(px / 32) : 6'd0;
        er = (von && py < 448) ? 4'(py / 64) : 4'd0;
        chk("cout", {6'd0, cout}, {6'd0, ec});
        chk("rout", {8'd0, rout}, {8'd0, er});
        if (q.size() >= 4) begin
            ex = q.pop_front();
            chk("rgb", rgb, ex.rgb);
            chk("hsync_out", {11'd0, hsync_out}, {11'd0, ex.hs});
            chk("vsync_out", {11'd0, vsync_out}, {11'd0, ex.vs});
        end
    endtask

    task automatic check_reset_values();
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_hs", {11'd0, hsync_out}, 12'd1);
        chk("rst_vs", {11'd0, vsync_out}, 12'd1);
        chk("rst_cout", {6'd0, cout}, 12'd0);
        chk("rst_rout", {8'd0, rout}, 12'd0);
        chk("rst_faddr", font_addr, 12'd0);
    endtask

    task automatic line(input int py);
        for (int px = 0; px < 800; px++) step(px, py);
    endtask

    initial begin
        reset = 1'b1;
        x = 10'd0; y = 10'd0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        cursor_col = 6'd0; cursor_row = 4'd0; cursor_en = 1'b0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++) plane[r][c] = 8'd129;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);

        // Reset state, then release between edges
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;
        prefill();

        // All-blank plane: background everywhere, border rows, blanking region
        line(0);
        line(63);
        line(447);
        line(479);

        // Single glyph 0x41 at (r2,c5), font row 0 = 1000_0001
        plane[2][5] = 8'h41;
        rom[{8'h41, 4'h0}] = 8'b1000_0001;
        line(128);

        // Cursor at (0,0) blinking every 4 clk on the underline band, then out of range
        cursor_en = 1'b1;
        line(56);
        line(63);
        cursor_col = 6'd25;
        line(60);

        // Reset asserted mid-line: immediate reset values, then a 4-edge refill
        for (int px = 0; px < 300; px++) step(px, 130);
        reset = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;
        prefill();
        for (int px = 300; px < 800; px++) step(px, 130);

        // Randomized planes, fonts and cursors
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++)
                case ($urandom_range(0, 5))
                    0: plane[r][c] = 8'd129;
                    1: plane[r][c] = 8'hFF;
                    default: plane[r][c] = 8'($urandom);
                endcase
        for (int n = 0; n < 10; n++) begin
            cursor_en  = ($urandom_range(0, 3) != 0);
            cursor_col = 6'($urandom_range(0, 21));
            cursor_row = 4'($urandom_range(0, 7));
            if (n % 2 == 0) line(int'(cursor_row) * 64 + 56 + $urandom_range(0, 7));
            else line($urandom_range(0, 479));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
